// File: rtl/zcrv_wb_arbiter_if.sv
// Writeback arbiter bus bundle: producer results, long-latency issue, regfile write port and
// decode source lookups.
// Optional feature macro: ZCRV_WB_BYPASS_EN adds the write-stage forward signals.
// The slave modport is the arbiter's view. The master modport is the view of the surrounding
// pipeline (producers, decode, regfile).
interface zcrv_wb_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5
);
  logic            issue_en;
  logic [RAW-1:0]  issue_rd;
  logic            alu_vld;
  logic [RAW-1:0]  alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_vld;
  logic            lsu_rdy;
  logic [RAW-1:0]  lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            mul_vld;
  logic            mul_rdy;
  logic [RAW-1:0]  mul_rd;
  logic [XLEN-1:0] mul_data;
  logic            rd_wr_en;
  logic [RAW-1:0]  rd_index;
  logic [XLEN-1:0] rd_data;
  logic [RAW-1:0]  rs1_index;
  logic [RAW-1:0]  rs2_index;
  logic            rs1_busy;
  logic            rs2_busy;
`ifdef ZCRV_WB_BYPASS_EN
  logic            rs1_fwd_vld;
  logic            rs2_fwd_vld;
  logic [XLEN-1:0] rs1_fwd_data;
  logic [XLEN-1:0] rs2_fwd_data;

  modport slave (
    input  issue_en, issue_rd,
    input  alu_vld, alu_rd, alu_data,
    input  lsu_vld, lsu_rd, lsu_data,
    output lsu_rdy,
    input  mul_vld, mul_rd, mul_data,
    output mul_rdy,
    output rd_wr_en, rd_index, rd_data,
    input  rs1_index, rs2_index,
    output rs1_busy, rs2_busy,
    output rs1_fwd_vld, rs2_fwd_vld, rs1_fwd_data, rs2_fwd_data
  );

  modport master (
    output issue_en, issue_rd,
    output alu_vld, alu_rd, alu_data,
    output lsu_vld, lsu_rd, lsu_data,
    input  lsu_rdy,
    output mul_vld, mul_rd, mul_data,
    input  mul_rdy,
    input  rd_wr_en, rd_index, rd_data,
    output rs1_index, rs2_index,
    input  rs1_busy, rs2_busy,
    input  rs1_fwd_vld, rs2_fwd_vld, rs1_fwd_data, rs2_fwd_data
  );
`else
  modport slave (
    input  issue_en, issue_rd,
    input  alu_vld, alu_rd, alu_data,
    input  lsu_vld, lsu_rd, lsu_data,
    output lsu_rdy,
    input  mul_vld, mul_rd, mul_data,
    output mul_rdy,
    output rd_wr_en, rd_index, rd_data,
    input  rs1_index, rs2_index,
    output rs1_busy, rs2_busy
  );

  modport master (
    output issue_en, issue_rd,
    output alu_vld, alu_rd, alu_data,
    output lsu_vld, lsu_rd, lsu_data,
    input  lsu_rdy,
    output mul_vld, mul_rd, mul_data,
    input  mul_rdy,
    input  rd_wr_en, rd_index, rd_data,
    output rs1_index, rs2_index,
    input  rs1_busy, rs2_busy
  );
`endif
endinterface

// File: rtl/zcrv_wb_arbiter.sv
// Writeback arbiter and scoreboard.
// ALU results win outright; LSU and MUL share the regfile write port round-robin. A busy bit per
// register tracks outstanding LSU/MUL destinations so decode can stall on RAW hazards.
// Optional feature macro: ZCRV_WB_BYPASS_EN forwards the write-stage result to decode instead of
// stalling on it.
module zcrv_wb_arbiter #(
  parameter int unsigned XLEN = 32,  // ZCRV_XLEN
  parameter int unsigned RAW  = 5    // ZCRV_REG_SIZE
) (
  input logic              clk,
  input logic              rst,
  zcrv_wb_arbiter_if.slave bus
);

  localparam int unsigned NumRegs = 1 << RAW;

  typedef enum logic {
    PrioLsu = 1'b0,
    PrioMul = 1'b1
  } prio_e;

  prio_e prio_q, prio_d;

  logic            lsu_rdy, mul_rdy;
  logic            lsu_xfer, mul_xfer;
  logic            grant;
  logic [RAW-1:0]  wb_rd;
  logic [XLEN-1:0] wb_data;

  logic [NumRegs-1:0] busy_q, busy_d;

  logic            rd_wr_en_q;
  logic [RAW-1:0]  rd_index_q;
  logic [XLEN-1:0] rd_data_q;

  logic rs1_hit, rs2_hit;
  logic rs1_sb, rs2_sb;

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PrioLsu;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Ready generation, grant selection and pointer update.
  always_comb begin
    lsu_rdy = 1'b0;
    mul_rdy = 1'b0;
    grant   = 1'b0;
    wb_rd   = '0;
    wb_data = '0;
    prio_d  = prio_q;
    // Readies ignore the unit's own valid so producers see a stable ready.
    if (!rst) begin
      lsu_rdy = !bus.alu_vld && (!bus.mul_vld || (prio_q == PrioLsu));
      mul_rdy = !bus.alu_vld && (!bus.lsu_vld || (prio_q == PrioMul));
    end
    lsu_xfer = bus.lsu_vld && lsu_rdy;
    mul_xfer = bus.mul_vld && mul_rdy;
    if (!rst && bus.alu_vld) begin
      grant   = 1'b1;
      wb_rd   = bus.alu_rd;
      wb_data = bus.alu_data;
    end else if (lsu_xfer) begin
      grant   = 1'b1;
      wb_rd   = bus.lsu_rd;
      wb_data = bus.lsu_data;
      prio_d  = PrioMul;
    end else if (mul_xfer) begin
      grant   = 1'b1;
      wb_rd   = bus.mul_rd;
      wb_data = bus.mul_data;
      prio_d  = PrioLsu;
    end
  end

  // Scoreboard next state: clears from LSU/MUL transfers, then issue sets (set wins).
  always_comb begin
    busy_d = busy_q;
    if (lsu_xfer) begin
      busy_d[bus.lsu_rd] = 1'b0;
    end
    if (mul_xfer) begin
      busy_d[bus.mul_rd] = 1'b0;
    end
    if (bus.issue_en && (bus.issue_rd != '0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Write stage and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      rd_wr_en_q <= 1'b0;
      rd_index_q <= '0;
      rd_data_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      // Results to x0 are accepted but never written.
      rd_wr_en_q <= grant && (wb_rd != '0);
      if (grant) begin
        rd_index_q <= wb_rd;
        rd_data_q  <= wb_data;
      end
    end
  end

  assign bus.lsu_rdy  = lsu_rdy;
  assign bus.mul_rdy  = mul_rdy;
  assign bus.rd_wr_en = rd_wr_en_q;
  assign bus.rd_index = rd_index_q;
  assign bus.rd_data  = rd_data_q;

  assign rs1_hit = !rst && rd_wr_en_q && (rd_index_q == bus.rs1_index) && (bus.rs1_index != '0);
  assign rs2_hit = !rst && rd_wr_en_q && (rd_index_q == bus.rs2_index) && (bus.rs2_index != '0);
  assign rs1_sb  = !rst && busy_q[bus.rs1_index];
  assign rs2_sb  = !rst && busy_q[bus.rs2_index];

`ifdef ZCRV_WB_BYPASS_EN
  assign bus.rs1_busy     = rs1_sb;
  assign bus.rs2_busy     = rs2_sb;
  assign bus.rs1_fwd_vld  = rs1_hit;
  assign bus.rs2_fwd_vld  = rs2_hit;
  assign bus.rs1_fwd_data = rd_data_q;
  assign bus.rs2_fwd_data = rd_data_q;
`else
  // A value in the write stage is not yet in the regfile, so decode stalls one cycle.
  assign bus.rs1_busy = rs1_sb || rs1_hit;
  assign bus.rs2_busy = rs2_sb || rs2_hit;
`endif

endmodule

// File: tb/tb_zcrv_wb_arbiter.sv
// Testbench for zcrv_wb_arbiter: directed scenarios followed by randomized traffic, all checked
// against a behavioural model of the arbitration, write stage and scoreboard.
// Honours ZCRV_WB_BYPASS_EN the same way as the design.
module tb_zcrv_wb_arbiter;

  logic clk;
  logic rst;

  zcrv_wb_arbiter_if #(.XLEN(32), .RAW(5)) bus ();

  zcrv_wb_arbiter #(
    .XLEN(32),
    .RAW (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state.
  bit          m_busy[32];
  int          m_prio;    // 0: LSU preferred, 1: MUL preferred
  bit          m_wr;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  bit          lsu_taken;
  bit          mul_taken;

`ifdef ZCRV_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_prio    = 0;
    m_wr      = 1'b0;
    m_idx     = '0;
    m_data    = '0;
    lsu_taken = 1'b0;
    mul_taken = 1'b0;
  endtask

  // Compare every output against the model, away from the active edge.
  task automatic sample();
    bit e_lsu_rdy, e_mul_rdy, e_hit1, e_hit2;
    @(negedge clk);
    e_lsu_rdy = !rst && !bus.alu_vld && (!bus.mul_vld || m_prio == 0);
    e_mul_rdy = !rst && !bus.alu_vld && (!bus.lsu_vld || m_prio == 1);
    e_hit1 = !rst && m_wr && (m_idx == bus.rs1_index) && (bus.rs1_index != 0);
    e_hit2 = !rst && m_wr && (m_idx == bus.rs2_index) && (bus.rs2_index != 0);
    check_val("lsu_rdy", bus.lsu_rdy, e_lsu_rdy);
    check_val("mul_rdy", bus.mul_rdy, e_mul_rdy);
    check_val("rd_wr_en", bus.rd_wr_en, m_wr);
    check_val("rd_index", bus.rd_index, m_idx);
    check_val("rd_data", bus.rd_data, m_data);
    check_val("rs1_busy", bus.rs1_busy,
              (!rst && m_busy[bus.rs1_index]) || (!Bypass && e_hit1));
    check_val("rs2_busy", bus.rs2_busy,
              (!rst && m_busy[bus.rs2_index]) || (!Bypass && e_hit2));
`ifdef ZCRV_WB_BYPASS_EN
    check_val("rs1_fwd_vld", bus.rs1_fwd_vld, e_hit1);
    check_val("rs2_fwd_vld", bus.rs2_fwd_vld, e_hit2);
    if (e_hit1) check_val("rs1_fwd_data", bus.rs1_fwd_data, m_data);
    if (e_hit2) check_val("rs2_fwd_data", bus.rs2_fwd_data, m_data);
`endif
  endtask

  // Apply this cycle's inputs to the model, then step across the clock edge.
  task automatic advance();
    int win;  // 0 none, 1 ALU, 2 LSU, 3 MUL
    win = 0;
    if (!rst) begin
      if (bus.alu_vld) win = 1;
      else if (bus.lsu_vld && bus.mul_vld) win = (m_prio == 0) ? 2 : 3;
      else if (bus.lsu_vld) win = 2;
      else if (bus.mul_vld) win = 3;
    end
    if (rst) begin
      model_reset();
    end else begin
      lsu_taken = (win == 2);
      mul_taken = (win == 3);
      m_wr = 1'b0;
      case (win)
        1: begin m_idx = bus.alu_rd; m_data = bus.alu_data; m_wr = (bus.alu_rd != 0); end
        2: begin m_idx = bus.lsu_rd; m_data = bus.lsu_data; m_wr = (bus.lsu_rd != 0); end
        3: begin m_idx = bus.mul_rd; m_data = bus.mul_data; m_wr = (bus.mul_rd != 0); end
        default: ;
      endcase
      if (win == 2) begin m_busy[bus.lsu_rd] = 1'b0; m_prio = 1; end
      if (win == 3) begin m_busy[bus.mul_rd] = 1'b0; m_prio = 0; end
      if (bus.issue_en && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.issue_en = 0; bus.issue_rd = '0;
    bus.alu_vld = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_vld = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.mul_vld = 0; bus.mul_rd = '0; bus.mul_data = '0;
    bus.rs1_index = '0; bus.rs2_index = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset mid-operation with results pending; LSU must be granted first afterwards.
    bus.issue_en = 1; bus.issue_rd = 5'd5; bus.rs1_index = 5'd5;
    sample(); advance();
    bus.issue_en = 0;
    bus.lsu_vld = 1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'hA1;
    sample(); check_val("pre_rst_rs1_busy", bus.rs1_busy, 1); advance();
    bus.lsu_rd = 5'd6; bus.lsu_data = 32'hA2;
    bus.mul_vld = 1; bus.mul_rd = 5'd8; bus.mul_data = 32'hB1;
    rst = 1'b1;
    sample(); check_val("rst_lsu_rdy", bus.lsu_rdy, 0); advance();
    sample();
    check_val("rst_rd_wr_en", bus.rd_wr_en, 0);
    check_val("rst_rs1_busy", bus.rs1_busy, 0);
    check_val("rst_lsu_rdy2", bus.lsu_rdy, 0);
    advance();
    rst = 1'b0;
    sample();
    check_val("post_rst_lsu_first", bus.lsu_rdy, 1);
    check_val("post_rst_mul_wait", bus.mul_rdy, 0);
    advance();
    bus.lsu_vld = 0;
    sample(); check_val("post_rst_rd_index", bus.rd_index, 6); advance();
    bus.mul_vld = 0;
    sample(); check_val("mul_rd_index", bus.rd_index, 8); check_val("mul_rd_data", bus.rd_data, 32'hB1);
    advance();

    // ALU priority for three cycles, then LSU/MUL alternate.
    bus.alu_vld = 1;
    bus.lsu_vld = 1; bus.lsu_rd = 5'd10; bus.lsu_data = 32'hC0;
    bus.mul_vld = 1; bus.mul_rd = 5'd11; bus.mul_data = 32'hD0;
    for (int i = 0; i < 3; i++) begin
      bus.alu_rd = 5'(i + 1); bus.alu_data = 32'hA000 + 32'(i);
      sample();
      if (i > 0) check_val("alu_rd_index", bus.rd_index, i);
      check_val("alu_blocks_lsu", bus.lsu_rdy, 0);
      check_val("alu_blocks_mul", bus.mul_rdy, 0);
      advance();
    end
    bus.alu_vld = 0;
    for (int k = 0; k < 4; k++) begin
      sample();
      if (k == 0) check_val("alu_last_index", bus.rd_index, 3);
      check_val("rr_lsu_rdy", bus.lsu_rdy, (k % 2 == 0));
      check_val("rr_mul_rdy", bus.mul_rdy, (k % 2 == 1));
      advance();
      if (lsu_taken) begin bus.lsu_rd = 5'(12 + k); bus.lsu_data = 32'hC1 + 32'(k); end
      if (mul_taken) begin bus.mul_rd = 5'(16 + k); bus.mul_data = 32'hD1 + 32'(k); end
    end
    bus.lsu_vld = 0; bus.mul_vld = 0;

    // Scoreboard: MUL to x7 returns four cycles after issue.
    bus.issue_en = 1; bus.issue_rd = 5'd7; bus.rs1_index = 5'd7;
    sample(); advance();
    bus.issue_en = 0;
    for (int i = 0; i < 4; i++) begin
      sample(); check_val("sb_rs1_busy", bus.rs1_busy, 1); advance();
    end
    bus.mul_vld = 1; bus.mul_rd = 5'd7; bus.mul_data = 32'hDEADBEEF;
    sample(); check_val("sb_busy_at_xfer", bus.rs1_busy, 1); check_val("sb_mul_rdy", bus.mul_rdy, 1);
    advance();
    bus.mul_vld = 0;
    sample();
    check_val("sb_wr_en", bus.rd_wr_en, 1);
    check_val("sb_index", bus.rd_index, 7);
    check_val("sb_data", bus.rd_data, 32'hDEADBEEF);
    check_val("sb_wb_stage_busy", bus.rs1_busy, !Bypass);
    advance();
    sample(); check_val("sb_cleared", bus.rs1_busy, 0); advance();

    // Result to x0 is accepted but not written.
    bus.lsu_vld = 1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h55;
    sample(); check_val("x0_lsu_rdy", bus.lsu_rdy, 1); advance();
    bus.lsu_vld = 0;
    sample(); check_val("x0_no_write", bus.rd_wr_en, 0); advance();

    // Issue and transfer to the same register in one cycle: the set wins.
    bus.issue_en = 1; bus.issue_rd = 5'd3; bus.rs1_index = 5'd3;
    sample(); advance();
    bus.lsu_vld = 1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h33;
    sample(); advance();
    bus.issue_en = 0; bus.lsu_vld = 0;
    sample(); advance();
    sample(); check_val("collide_busy3", bus.rs1_busy, 1); advance();

    // Write stage holding x9 while decode reads it on rs2.
    bus.alu_vld = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'h12345678; bus.rs2_index = 5'd9;
    sample(); advance();
    bus.alu_vld = 0;
    sample();
`ifdef ZCRV_WB_BYPASS_EN
    check_val("byp_fwd_vld", bus.rs2_fwd_vld, 1);
    check_val("byp_fwd_data", bus.rs2_fwd_data, 32'h12345678);
    check_val("byp_rs2_busy", bus.rs2_busy, 0);
`else
    check_val("nobyp_rs2_busy", bus.rs2_busy, 1);
`endif
    advance();

    // Randomized traffic; producers hold their result until it is accepted.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.alu_vld  = ($urandom_range(0, 3) == 0);
      bus.alu_rd   = 5'($urandom_range(0, 7));
      bus.alu_data = 32'($urandom);
      if (!bus.lsu_vld || lsu_taken) begin
        bus.lsu_vld  = 1'($urandom_range(0, 1));
        bus.lsu_rd   = 5'($urandom_range(0, 7));
        bus.lsu_data = 32'($urandom);
      end
      if (!bus.mul_vld || mul_taken) begin
        bus.mul_vld  = 1'($urandom_range(0, 1));
        bus.mul_rd   = 5'($urandom_range(0, 7));
        bus.mul_data = 32'($urandom);
      end
      bus.issue_en  = ($urandom_range(0, 2) == 0);
      bus.issue_rd  = 5'($urandom_range(0, 7));
      bus.rs1_index = 5'($urandom_range(0, 7));
      bus.rs2_index = 5'($urandom_range(0, 7));
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/zcrv_wb_arbiter.md
# zcrv_wb_arbiter

- Writeback arbiter and scoreboard that drives the regfile write port (`rd_wr_en`/`rd_index`/`rd_data`).
- Merges results from three producers onto the single write port: single-cycle ALU, load/store unit (LSU) and multi-cycle multiplier (MUL).
- Tracks outstanding long-latency destinations so the decode stage can stall on RAW hazards.
- Sits between the execute units and the regfile, with its busy outputs feeding decode.

## Interface
Parameters:
- `XLEN`, default `ZCRV_XLEN` (32): data width.
- `RAW`, default `ZCRV_REG_SIZE` (5): register index width.

Ports:
- `clk`  in  1  core clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `issue_en`  in  1  decode issued an LSU/MUL op writing `issue_rd`.
- `issue_rd`  in  RAW  destination of the issued long-latency op.
- `alu_vld`  in  1  ALU result valid; no backpressure.
- `alu_rd`  in  RAW  ALU destination.
- `alu_data`  in  XLEN  ALU result.
- `lsu_vld`  in  1  LSU result valid.
- `lsu_rdy`  out  1  LSU result accepted this cycle.
- `lsu_rd`  in  RAW  LSU destination.
- `lsu_data`  in  XLEN  LSU result.
- `mul_vld`  in  1  MUL result valid.
- `mul_rdy`  out  1  MUL result accepted this cycle.
- `mul_rd`  in  RAW  MUL destination.
- `mul_data`  in  XLEN  MUL result.
- `rd_wr_en`  out  1  regfile write enable (registered).
- `rd_index`  out  RAW  regfile write index (registered).
- `rd_data`  out  XLEN  regfile write data (registered).
- `rs1_index`  in  RAW  decode source 1.
- `rs2_index`  in  RAW  decode source 2.
- `rs1_busy`  out  1  source 1 not yet readable; decode must stall.
- `rs2_busy`  out  1  source 2 not yet readable; decode must stall.
- `rs1_fwd_vld`, `rs2_fwd_vld`  out  1  forward hit (`ZCRV_WB_BYPASS_EN` only).
- `rs1_fwd_data`, `rs2_fwd_data`  out  XLEN  forwarded value (`ZCRV_WB_BYPASS_EN` only).

## Operation
- Arbitration: ALU has absolute priority. When `alu_vld`=0, LSU and MUL share the port round-robin.
- Round-robin pointer `prio`: reset value is LSU; it toggles to the other unit after each LSU or MUL grant.
- Ready outputs are combinational and do not depend on the unit's own valid:
  - `lsu_rdy = !alu_vld & (!mul_vld | prio==LSU)`
  - `mul_rdy = !alu_vld & (!lsu_vld | prio==MUL)`
- A transfer occurs when `vld & rdy`. Producers hold `vld`/`rd`/`data` stable until accepted.
- Write stage: the granted result is registered into `rd_*`. `rd_wr_en`=1 only if a grant occurred and the destination is not 0; results to x0 are accepted and dropped. With no grant, `rd_wr_en`=0 and `rd_index`/`rd_data` hold their previous values.
- Scoreboard: `busy[31:1]`; `busy[0]` is constant 0.
  - `issue_en` with `issue_rd`≠0 sets `busy[issue_rd]`.
  - An LSU/MUL transfer clears `busy[rd]`.
  - ALU results never touch `busy`.
  - Set and clear of the same register in the same cycle: set wins.
  - Issuing to an already-busy register leaves it busy. Decode must not do this (WAW stall lives upstream); no error is flagged.
- `rsN_busy` = `busy[rsN_index]`, OR (without bypass) a write-stage hit: `rd_wr_en & rd_index==rsN_index & rsN_index≠0`.

## Timing
- Reset: all outputs 0, all `busy` bits 0, `prio`=LSU, pending write discarded. This also applies to reset asserted mid-operation.
- Latency: one cycle from transfer to `rd_wr_en` high. The regfile is updated at the following edge.
- Throughput: one write per cycle. With continuous ALU traffic, LSU and MUL starve. Fairness is guaranteed only between LSU and MUL.
- `busy` clears at the edge that captures the transfer, i.e. the same edge that asserts `rd_wr_en`.
- `rsN_busy` and the forward outputs are combinational from registered state and the `rsN_index` inputs.

## Configuration
- `ZCRV_WB_BYPASS_EN` defined:
  - `rsN_fwd_vld = rd_wr_en & rd_index==rsN_index & rsN_index≠0`, and `rsN_fwd_data = rd_data`.
  - The write-stage hit is removed from `rsN_busy`, so decode uses the forwarded value instead of stalling.
- Undefined:
  - Forward ports are absent.
  - The write-stage hit asserts `rsN_busy` for that one cycle.

## Test plan
- Reset check: assert `rst` with `lsu_vld`=1 pending. Required: `rd_wr_en`=0, `lsu_rdy`=0 and `rs1_busy`=0 for `rs1_index`=5; after release, LSU is granted first.
- Priority: `alu_vld`, `lsu_vld` and `mul_vld` all 1 for 3 cycles, then ALU drops.
  - Required: `rd_index` shows ALU for 3 writes.
  - Then LSU, then MUL alternate with `lsu_rdy`/`mul_rdy` toggling each cycle.
- Scoreboard: `issue_en`, `issue_rd`=7; MUL returns rd=7, data 0xDEADBEEF, 4 cycles later.
  - Required: `rs1_busy`=1 for `rs1_index`=7 until the transfer edge.
  - Then `rd_wr_en`=1, `rd_index`=7, `rd_data`=0xDEADBEEF.
- x0 and collisions:
  - LSU result to rd=0: accepted, `rd_wr_en`=0.
  - `issue_en` to rd=3 in the same cycle as an LSU transfer to rd=3: `busy[3]` stays 1.
- Bypass (macro on): write stage holds rd=9, data 0x12345678 while `rs2_index`=9. Required: `rs2_fwd_vld`=1, `rs2_fwd_data`=0x12345678, `rs2_busy`=0. With the macro off, the same stimulus gives `rs2_busy`=1.
